// File: rtl/pc_stack_unit.sv
// Program counter with absolute/relative transfers and a hardware
// call/return stack that has sticky overflow/underflow flags.
module pc_stack_unit #(
  parameter int ADDR_W      = 8,
  parameter int FLAG_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  localparam int SEL_W = (FLAG_W > 1) ? $clog2(FLAG_W) : 1,
  localparam int SP_W  = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HOLD,
  input  logic [2:0]        OP,
  input  logic [ADDR_W-1:0] TARGET,
  input  logic [FLAG_W-1:0] FLAGS,
  input  logic              COND_EN,
  input  logic [SEL_W-1:0]  COND_SEL,
  input  logic              COND_POL,
  input  logic              CLR_ERR,
  output logic [ADDR_W-1:0] ADDR,
  output logic              TAKEN,
  output logic [SP_W-1:0]   SP_LEVEL,
  output logic              STK_OVF,
  output logic              STK_UNF
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_JMP  = 3'b001,
    OP_BR   = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } op_e;

  function automatic logic [ADDR_W-1:0] inc_wrap(input logic [ADDR_W-1:0] base);
    inc_wrap = base + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] add_wrap(input logic [ADDR_W-1:0] base,
                                                 input logic signed [ADDR_W-1:0] ofs);
    add_wrap = base + $unsigned(ofs);
  endfunction

  logic [ADDR_W-1:0] pc_p1;
  logic              taken_p1;
  logic [SP_W-1:0]   sp_p1;
  logic              ovf_p1;
  logic              unf_p1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic                     cond;
  logic [ADDR_W-1:0]        seq_pc;
  logic [ADDR_W-1:0]        pc_nxt;
  logic                     taken_nxt;
  logic [SP_W-1:0]          sp_nxt;
  logic [SP_W-1:0]          sp_m1;
  logic                     push;
  logic                     ovf_set;
  logic                     unf_set;
  logic signed [ADDR_W-1:0] br_ofs;

  // Stage 0: decode operation against the live flag test and stack level
  always_comb begin
    cond      = ~COND_EN | (FLAGS[COND_SEL] == COND_POL);
    seq_pc    = inc_wrap(pc_p1);
    br_ofs    = $signed(TARGET);
    sp_m1     = sp_p1 - SP_W'(1);
    pc_nxt    = seq_pc;
    taken_nxt = 1'b0;
    sp_nxt    = sp_p1;
    push      = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    case (OP)
      OP_JMP: begin
        if (cond) begin
          pc_nxt    = TARGET;
          taken_nxt = 1'b1;
        end
      end
      OP_BR: begin
        if (cond) begin
          pc_nxt    = add_wrap(pc_p1, br_ofs);
          taken_nxt = 1'b1;
        end
      end
      OP_CALL: begin
        if (cond) begin
          if (sp_p1 < SP_W'(STACK_DEPTH)) begin
            push      = 1'b1;
            sp_nxt    = sp_p1 + SP_W'(1);
            pc_nxt    = TARGET;
            taken_nxt = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      OP_RET: begin
        if (cond) begin
          if (sp_p1 != '0) begin
            sp_nxt    = sp_m1;
            pc_nxt    = stack_mem[sp_m1[IDX_W-1:0]];
            taken_nxt = 1'b1;
          end else begin
            unf_set = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Stage 1: architectural state; a new error in the clearing cycle wins
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_p1    <= RESET_VEC;
      taken_p1 <= 1'b0;
      sp_p1    <= '0;
      ovf_p1   <= 1'b0;
      unf_p1   <= 1'b0;
    end else if (!HOLD) begin
      pc_p1    <= pc_nxt;
      taken_p1 <= taken_nxt;
      sp_p1    <= sp_nxt;
      ovf_p1   <= ovf_set | (ovf_p1 & ~CLR_ERR);
      unf_p1   <= unf_set | (unf_p1 & ~CLR_ERR);
    end
  end

  always_ff @(posedge CLK) begin
    if (!HOLD && push) stack_mem[sp_p1[IDX_W-1:0]] <= seq_pc;
  end

  assign ADDR     = pc_p1;
  assign TAKEN    = taken_p1;
  assign SP_LEVEL = sp_p1;
  assign STK_OVF  = ovf_p1;
  assign STK_UNF  = unf_p1;

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Next-generation program counter for the C0 datapath.
- Generalises the fixed 8-bit incrementing PC with flag-conditioned parallel load.
- Adds: parametrised address width, relative branches, and a hardware call/return stack with overflow and underflow detection.
- Sits between the instruction decoder (OP, TARGET, condition fields), the flag register (FLAGS) and instruction memory (ADDR).

Parameters:
- ADDR_W, 8: PC and stack entry width in bits.
- FLAG_W, 8: width of the flag vector.
- STACK_DEPTH, 4: number of return-address entries (>=1).
- RESET_VEC, 0: ADDR value after reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- HOLD  in  1  freeze: no PC, stack or flag update this cycle.
- OP  in  3  000 NEXT, 001 JMP (absolute), 010 BR (relative), 011 CALL, 100 RET; 101-111 behave as NEXT.
- TARGET  in  ADDR_W  absolute address (JMP/CALL) or two's-complement offset (BR); ignored for NEXT/RET.
- FLAGS  in  FLAG_W  current flag register contents.
- COND_EN  in  1  0 = unconditional; 1 = gated by flag test.
- COND_SEL  in  clog2(FLAG_W)  index of the tested flag.
- COND_POL  in  1  condition true when FLAGS[COND_SEL] == COND_POL.
- CLR_ERR  in  1  clears the sticky error flags.
- ADDR  out  ADDR_W  current PC, registered.
- TAKEN  out  1  registered; 1 when the previous update performed a control transfer.
- SP_LEVEL  out  clog2(STACK_DEPTH+1)  number of valid stack entries.
- STK_OVF  out  1  sticky overflow flag.
- STK_UNF  out  1  sticky underflow flag.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - ADDR = RESET_VEC; SP_LEVEL = 0; TAKEN = 0; STK_OVF = 0; STK_UNF = 0.
  - Stack contents are don't-care.
- Priority: RST > HOLD > OP.
- HOLD = 1: all registers keep their value, including TAKEN and the error flags. CLR_ERR is also ignored.
- cond = ~COND_EN | (FLAGS[COND_SEL] == COND_POL). The condition is evaluated combinationally in the same cycle as OP.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W. Defaults: 255 + 1 = 0; BR with offset 0xFE from 0x01 gives 0xFF.
- Per rising edge, when not held:
  - NEXT: ADDR <= ADDR+1; TAKEN <= 0.
  - JMP: if cond, ADDR <= TARGET and TAKEN <= 1; else ADDR <= ADDR+1 and TAKEN <= 0.
  - BR: if cond, ADDR <= ADDR + TARGET (signed, relative to the current instruction) and TAKEN <= 1; else as NEXT. Offset 0 is a legal self-loop.
  - CALL, cond true, SP_LEVEL < STACK_DEPTH:
    - stack[SP_LEVEL] <= ADDR+1 (wrapped); SP_LEVEL++.
    - ADDR <= TARGET; TAKEN <= 1.
  - CALL, cond true, stack full:
    - No push, no jump: ADDR <= ADDR+1; TAKEN <= 0; STK_OVF <= 1.
  - RET, cond true, SP_LEVEL > 0:
    - ADDR <= stack[SP_LEVEL-1]; SP_LEVEL--; TAKEN <= 1.
  - RET, cond true, stack empty:
    - ADDR <= ADDR+1; TAKEN <= 0; STK_UNF <= 1.
  - CALL or RET with cond false: behaves as NEXT; stack and error flags untouched.
- Error flags:
  - Sticky until CLR_ERR = 1, which clears them on the next edge.
  - If an error occurs in the same cycle as CLR_ERR, set wins.
- Stack is strictly LIFO.
- Only the entry at the push index is written; other entries hold.
- Latency: ADDR reflects OP one cycle after the edge that samples it. No combinational path from inputs to outputs.

Test Plan:
1. Reset and increment: RST pulse with RESET_VEC = 0, then 3 NEXT cycles -> ADDR 0, 1, 2, 3; TAKEN = 0; SP_LEVEL = 0. Run from 0xFE with 2 NEXT -> 0xFF, then 0x00.
2. Conditional jump: ADDR = 5, OP = JMP, TARGET = 251, COND_EN = 1, COND_SEL = 2, COND_POL = 1.
   - FLAGS = 0x04 -> ADDR = 251, TAKEN = 1.
   - Repeat with FLAGS = 0x00 -> ADDR = 6, TAKEN = 0.
3. Relative branch: ADDR = 0x10.
   - BR with TARGET = 0xFC (-4), unconditional -> ADDR = 0x0C.
   - BR with TARGET = 0x05 -> ADDR = 0x11.
4. Call/return nesting, STACK_DEPTH = 4:
   - CALL at 0x10 -> 0x40; CALL at 0x40 -> 0x80. SP_LEVEL = 2.
   - RET -> ADDR = 0x41, SP_LEVEL = 1; RET -> ADDR = 0x11, SP_LEVEL = 0.
   - Extra RET -> ADDR = 0x12, STK_UNF = 1.
   - CLR_ERR -> STK_UNF = 0.
5. Overflow: 4 CALLs fill the stack (SP_LEVEL = 4).
   - 5th CALL at 0x30 to 0x90 -> ADDR = 0x31, STK_OVF = 1, SP_LEVEL = 4.
   - Then 4 RETs return in exact LIFO order.
6. HOLD and async reset:
   - HOLD = 1 during CALL -> ADDR, SP_LEVEL and TAKEN unchanged.
   - Assert RST between clock edges while SP_LEVEL = 2 -> ADDR = RESET_VEC and SP_LEVEL = 0 immediately, without waiting for a clock edge.
